// File: rtl/replica_pkg.sv
// Shared types and sizes for the replica ordering RAMs and the host-side
// route loader that fills them.
package replica_pkg;

   // City index width and number of packed words per replica tour.
   localparam int city_num_log = 4;
   localparam int city_div     = 2;
   localparam int city_div_log = 1;

   // Base ID width: one base ID per replica slot in the exchange node.
   localparam int base_log     = 3;

   // Eight cities are packed per RAM word.
   localparam int lane_num     = 8;
   localparam int lane_log     = 3;

   // Lane i of a word holds city (word * 8 + i); lane 0 is the LSBs.
   typedef logic [lane_num-1:0][city_num_log-1:0] replica_data_t;

   // Command presented to the exchange node's in_ex_com port.
   typedef enum logic [1:0] {
      EX_NOP  = 2'd0,
      EX_SELF = 2'd1,
      EX_SWAP = 2'd2,
      EX_READ = 2'd3
   } exchange_command_t;

   // Loader sequencing: wait for start, stream words, announce completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2
   } loader_state_t;

endpackage

// File: rtl/city_packer.sv
// Eight-lane city packer. Each load writes one city into the addressed lane;
// the load into the top lane completes the word. The completed word is
// presented combinationally with the incoming city merged into its lane, so
// the parent can register it on the same edge the last city is accepted.
module city_packer
   import replica_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [lane_log-1:0]     lane,
   input  logic [city_num_log-1:0] city,
   output logic                    word_complete,
   output replica_data_t           word
);

   replica_data_t lanes_q;

   // Lane storage: only the addressed lane changes on a load; other lanes
   // keep their contents across input gaps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lanes_q <= '0;
      end else if (load) begin
         lanes_q[lane] <= city;
      end
   end

   // Forward the incoming city into its lane so the finished word is visible
   // in the same cycle as the final load.
   always_comb begin
      word       = lanes_q;
      word[lane] = city;
   end

   assign word_complete = load && (lane == lane_log'(lane_num - 1));

endmodule

// File: rtl/route_loader.sv
// Host-side route loader. Accepts one city per beat and writes packed words
// into the exchange node's self write port, city_div words per replica,
// across a contiguous (wrapping) range of base IDs.
//
// Handshake: a city beat transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state (high in
// LOAD), never on in_valid, and the host may hold or drop in_valid freely.
// The write side has no back-pressure: self_valid is a one-cycle strobe the
// node must take.
module route_loader
   import replica_pkg::*;
#(
   parameter bit check_last = 1'b1
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [base_log-1:0]     start_base,
   input  logic [base_log:0]       num_base,
   input  logic                    in_valid,
   input  logic [city_num_log-1:0] in_city,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic                    self_valid,
   output replica_data_t           self_data,
   output logic [base_log-1:0]     ex_base_id_w,
   output exchange_command_t       ex_com,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [1:0]              dbg_state
);

   localparam logic [city_div_log-1:0] word_last  = city_div_log'(city_div - 1);
   localparam logic [lane_log-1:0]     lane_last  = lane_log'(lane_num - 1);
   localparam logic [base_log:0]       remain_one = (base_log + 1)'(1);

   loader_state_t state_q;
   loader_state_t state_d;

   logic [lane_log-1:0]     lane_q;
   logic [city_div_log-1:0] word_q;
   logic [base_log-1:0]     base_q;
   logic [base_log:0]       remain_q;
   logic                    err_q;
   logic                    done_q;

   logic                    start_ok;
   logic                    accept;
   logic                    final_beat;
   logic                    word_complete;
   replica_data_t           packed_word;

   // A start is only honoured from IDLE; in LOAD or FIN it has no effect.
   assign start_ok = start && (state_q == IDLE);

   // Beat acceptance uses the state directly so there is no loop through
   // the in_ready output.
   assign accept = in_valid && (state_q == LOAD);

   // The very last city of the whole load: top lane of the last word of the
   // last remaining replica.
   assign final_beat = (remain_q == remain_one) && (word_q == word_last) &&
                       (lane_q == lane_last);

   city_packer u_packer (
      .clk           (clk),
      .reset         (reset),
      .load          (accept),
      .lane          (lane_q),
      .city          (in_city),
      .word_complete (word_complete),
      .word          (packed_word)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and state-decoded outputs.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      ex_com   = EX_NOP;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (num_base != '0) ? LOAD : FIN;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            ex_com   = EX_SELF;
            if (accept && final_beat) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Lane, word, base and replica counters plus the sticky framing error.
   // A word sequence, once started, always runs to city_div words so the
   // node's own write counter stays aligned; only reset cuts it short.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_q   <= '0;
         word_q   <= '0;
         base_q   <= '0;
         remain_q <= '0;
         err_q    <= 1'b0;
      end else if (start_ok) begin
         lane_q   <= '0;
         word_q   <= '0;
         base_q   <= start_base;
         remain_q <= num_base;
         err_q    <= 1'b0;
      end else if (accept) begin
         lane_q <= lane_q + 1'b1;
         if (lane_q == lane_last) begin
            if (word_q == word_last) begin
               word_q   <= '0;
               base_q   <= base_q + 1'b1;
               remain_q <= remain_q - 1'b1;
            end else begin
               word_q <= word_q + 1'b1;
            end
         end
         // in_last must coincide exactly with the final beat.
         if (check_last && (in_last != final_beat)) begin
            err_q <= 1'b1;
         end
      end
   end

   // Output register stage: the write strobe, its data and its base ID are
   // registered together, so ex_base_id_w only moves on a write edge and
   // holds for the whole write cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         self_valid   <= 1'b0;
         self_data    <= '0;
         ex_base_id_w <= '0;
      end else begin
         self_valid <= word_complete;
         if (word_complete) begin
            self_data    <= packed_word;
            ex_base_id_w <= base_q;
         end
      end
   end

   // done is registered out of FIN so it trails the last write strobe by
   // one cycle; reset clears it, so an aborted load never reports done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == FIN);
      end
   end

   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_route_loader.sv
// Bench for route_loader: table of load scenarios checked against a
// scoreboard of expected {base, word} writes, plus hand sequences for reset,
// empty loads and ignored starts.
`timescale 1ns/1ps
module tb_route_loader;
   import replica_pkg::*;

   localparam int W = base_log + lane_num * city_num_log;
   localparam int CITIES = lane_num * city_div;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    start = 1'b0;
   logic [base_log-1:0]     start_base = '0;
   logic [base_log:0]       num_base = '0;
   logic                    in_valid = 1'b0;
   logic [city_num_log-1:0] in_city = '0;
   logic                    in_last = 1'b0;
   logic                    in_ready;
   logic                    self_valid;
   replica_data_t           self_data;
   logic [base_log-1:0]     ex_base_id_w;
   exchange_command_t       ex_com;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [1:0]              dbg_state;

   route_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .start_base   (start_base),
      .num_base     (num_base),
      .in_valid     (in_valid),
      .in_city      (in_city),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .self_valid   (self_valid),
      .self_data    (self_data),
      .ex_base_id_w (ex_base_id_w),
      .ex_com       (ex_com),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .dbg_state    (dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int   start_base;
      int   num_base;
      int   gap_pct;
      int   last_idx;   // beat index carrying in_last, -1 for none
      int   city_xor;   // city pattern scrambler
      int   poke_at;    // beat index at which a stray start is pulsed, -1 none
      logic exp_err;
   } vec_t;

   vec_t vecs[6];

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int sv_count = 0;
   int done_count = 0;
   int last_sv_cyc = 0;
   int done_cyc = 0;
   int base_glitch = 0;
   int com_bad = 0;
   logic [base_log-1:0] prev_base = '0;

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (self_valid) begin
         got_q.push_back({ex_base_id_w, self_data});
         sv_count++;
         last_sv_cyc = cyc;
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (reset && (ex_base_id_w != prev_base) && !self_valid) base_glitch++;
      prev_base = ex_base_id_w;
      if (busy && ex_com != EX_SELF) com_bad++;
      if (!busy && ex_com != EX_NOP) com_bad++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_self_valid"}, self_valid, 0);
      check({tag, "_self_data"}, self_data, 0);
      check({tag, "_base_id"}, ex_base_id_w, 0);
      check({tag, "_ex_com"}, ex_com, EX_NOP);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   // Drive one complete load and check every write, done timing and err.
   task automatic run_case(input vec_t v, input string tag);
      int total;
      int idx;
      int guard;
      int sv0;
      int g;
      replica_data_t d;
      logic [W-1:0] e;
      logic [W-1:0] w;

      exp_q.delete();
      got_q.delete();
      for (int r = 0; r < v.num_base; r++) begin
         for (int wd = 0; wd < city_div; wd++) begin
            for (int i = 0; i < lane_num; i++) begin
               d[i] = city_num_log'((wd * lane_num + i) ^ v.city_xor);
            end
            exp_q.push_back({base_log'(v.start_base + r), d});
         end
      end
      sv0 = sv_count;

      @(negedge clk);
      start      = 1'b1;
      start_base = base_log'(v.start_base);
      num_base   = (base_log + 1)'(v.num_base);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_rise"}, busy, 1);
      check({tag, "_err_clear"}, err, 0);

      total = v.num_base * CITIES;
      idx   = 0;
      guard = 0;
      while (idx < total && guard < 4000) begin
         if (idx == v.poke_at) begin
            start      = 1'b1;
            start_base = base_log'(5);
            num_base   = (base_log + 1)'(2);
         end else begin
            start = 1'b0;
         end
         if (v.gap_pct > 0 && $urandom_range(99) < v.gap_pct) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_city  = city_num_log'((idx % CITIES) ^ v.city_xor);
            in_last  = (idx == v.last_idx);
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         guard++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check({tag, "_feed_timeout"}, guard < 4000, 1);
      check({tag, "_ready_drop"}, in_ready, 0);

      g = 0;
      while (!done && g < 100) begin
         @(negedge clk);
         g++;
      end
      check({tag, "_done_seen"}, done, 1);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_done_lat"}, done_cyc, last_sv_cyc + 1);
      check({tag, "_word_count"}, sv_count - sv0, exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         w = got_q.pop_front();
         check({tag, "_word"}, w, e);
      end
      check({tag, "_err"}, err, v.exp_err);
      if (v.exp_err) begin
         repeat (5) @(negedge clk);
         check({tag, "_err_sticky"}, err, 1);
      end
   endtask

   initial begin
      int sv0;
      int d0;
      vec_t rv;

      //            base n  gap last xor poke err
      vecs[0] = '{2, 1, 0,  15, 0,  -1, 1'b0};  // single replica
      vecs[1] = '{7, 3, 0,  47, 0,  -1, 1'b0};  // base wrap
      vecs[2] = '{2, 1, 50, 15, 0,  -1, 1'b0};  // gapped input
      vecs[3] = '{2, 1, 0,  7,  5,  -1, 1'b1};  // early in_last
      vecs[4] = '{4, 2, 25, 31, 9,  3,  1'b0};  // clears err, stray start
      vecs[5] = '{0, 1, 0,  -1, 3,  -1, 1'b1};  // missing in_last

      // Reset block.
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      reset = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         run_case(vecs[k], $sformatf("vec%0d", k));
      end

      // Reset in the middle of a load, after a framing error and 5 cities.
      sv0 = sv_count;
      d0  = done_count;
      @(negedge clk);
      start      = 1'b1;
      start_base = base_log'(3);
      num_base   = (base_log + 1)'(1);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_city  = city_num_log'(k + 9);
         in_last  = (k == 2);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("mid_err_set", err, 1);
      #2 reset = 1'b0;
      #1 check_reset_values("mid");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_no_write", sv_count, sv0);
      check("mid_no_done", done_count, d0);
      rv = '{6, 1, 0, 15, 10, -1, 1'b0};
      run_case(rv, "after_reset");

      // Empty load, with a start pulsed while in FIN.
      sv0 = sv_count;
      @(negedge clk);
      start      = 1'b1;
      start_base = base_log'(6);
      num_base   = '0;
      @(negedge clk);
      check("zero_busy", busy, 0);
      check("zero_state", dbg_state, 2);
      check("zero_done_early", done, 0);
      start    = 1'b1;
      num_base = (base_log + 1)'(1);
      @(negedge clk);
      start = 1'b0;
      check("zero_done", done, 1);
      check("fin_start_ignored", busy, 0);
      @(negedge clk);
      check("zero_done_pulse", done, 0);
      check("zero_idle", dbg_state, 0);
      repeat (3) @(negedge clk);
      check("zero_no_write", sv_count, sv0);

      check("base_stable", base_glitch, 0);
      check("ex_com_track", com_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
